dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the pipelined RISC-V core's store/load port: it accepts the core's `MemWrite`/`DataAdr`/`WriteData`/`MemWriteSelect` stores, backs them with byte-maskable word storage, and returns load data with one-cycle latency. It also decodes a memory-mapped completion register (`tohost`) so self-checking programs end with a hardware pass/fail verdict instead of bench-side address matching. It sits beside `top`'s core as the memory endpoint and is also instantiated stand-alone by memory-level benches.

## Interface
- `DEPTH`, 64: number of 32-bit words; power of two, ≥ 4.
- `TOHOST_ADDR`, 32'd100: byte address of the completion register; word-aligned; not backed by storage.
- `PASS_VALUE`, 32'd25: value that, written to `tohost`, means pass.
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low (asserted when 0); clears all state except array contents.
- `MemWrite` in 1: store strobe for the current cycle.
- `DataAdr` in 32: byte address for load or store.
- `WriteData` in 32: store data, lane-aligned (byte i on bits 8i+7:8i).
- `MemWriteSelect` in 4: byte-lane enables; bit i enables byte i.
- `ReadData` out 32: load data for the `DataAdr` of the previous cycle.
- `Done` out 1: a full-word store to `TOHOST_ADDR` has occurred; sticky.
- `Pass` out 1: `Done` and latched `tohost` value == `PASS_VALUE`.
- `Error` out 1: sticky; an illegal store was seen.
- `StoreCount` out 16: accepted stores to the array, saturating.

## Operation
- Word index = `DataAdr[log2(DEPTH)+1:2]`. An address is in range when `DataAdr < 4*DEPTH`.
- Legal masks: 4'b0001, 0010, 0100, 1000, 0011, 1100, 1111. Any other mask, including 0, is illegal.
- Store accepted (`MemWrite`=1, legal mask, in range, address ≠ `TOHOST_ADDR`): only enabled bytes update; `StoreCount` +1, saturating at 16'hFFFF.
- `tohost` store (`MemWrite`=1, `DataAdr`==`TOHOST_ADDR`):
  - With mask 1111 and `Done`=0: latch `WriteData`, set `Done`.
  - With any other mask: illegal; set `Error`.
  - After `Done`=1: ignored; the latched value is frozen and no flag changes.
  - Never touches the array or `StoreCount`.
- Illegal store (bad mask, or out of range and not `tohost`): dropped; `Error` set; `StoreCount` unchanged.
- `MemWrite`=0: `MemWriteSelect` and `WriteData` are ignored.
- Loads:
  - Every cycle, `ReadData` is registered from the word at `DataAdr`. No read strobe exists.
  - `DataAdr`==`TOHOST_ADDR` returns the latched `tohost` value.
  - Out of range returns 32'h0.
- Read-during-write to the same word returns the old contents (read-first).
- `Pass` is combinational from `Done` and the latched value.

## Timing
- Reset (`reset`=0, async) forces these values immediately: `ReadData`=0, `Done`=0, `Pass`=0, `Error`=0, `StoreCount`=0, `tohost` latch=0. Array contents are undefined and are not cleared.
- Reset released mid-operation: the first rising edge with `reset`=1 is the first active edge. Stores presented during reset are lost.
- Store latency: a store sampled at edge N is visible to a load sampled at edge N+1, with data on `ReadData` after N+1.
- Load latency: exactly 1 cycle, with back-to-back loads every cycle.
- `Done`/`Pass` assert 1 cycle after the `tohost` store edge.
- `Error` and `StoreCount` update on the same edge as the offending or accepted store.
- Stores can occur on consecutive cycles with no bubbles.

## Test plan
- Reset then basic store: hold `reset`=0 for 2 cycles, then store 32'h0000_0007 to address 96 with mask 1111; load 96 → `ReadData`=7, `StoreCount`=1, `Done`=0, `Error`=0.
- Byte lanes: fill word 8 with 32'hFFFF_FFFF, then store 32'h00AB_0000 with mask 0100 → load returns 32'hFFAB_FFFF. Then store 32'h1234_0000 with mask 1100 → load returns 32'h1234_FFFF.
- Completion: store 25 to address 100 with mask 1111 → next cycle `Done`=1, `Pass`=1. A later store of 3 to 100 leaves `Pass`=1, and a load of 100 returns 25.
- Fail path: store 26 to address 100 → `Done`=1, `Pass`=0, `Error`=0.
- Illegal stores: mask 0101 at address 0, then mask 1111 at address 4*`DEPTH` → `Error`=1 after the first edge, array word 0 unchanged, `StoreCount` unchanged.
- Read-first and async reset: load and store address 12 (old 5, new 9) on the same edge → `ReadData`=5, and the next load returns 9. Then pulse `reset`=0 mid-cycle → all outputs go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory endpoint for the core's load/store port: byte-maskable word
// storage, one-cycle registered loads, and a memory-mapped tohost verdict.
module dmem_responder #(
    parameter int unsigned DEPTH       = 64,
    parameter logic [31:0] TOHOST_ADDR = 32'd100,
    parameter logic [31:0] PASS_VALUE  = 32'd25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic [3:0]  MemWriteSelect,
    output logic [31:0] ReadData,
    output logic        Done,
    output logic        Pass,
    output logic        Error,
    output logic [15:0] StoreCount
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

    logic [31:0] mem_q [DEPTH];

    logic [31:0] rdata_q, rdata_d;
    logic [31:0] tohost_q, tohost_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [15:0] count_q, count_d;

    logic [AW-1:0] idx;
    logic          in_range;
    logic          is_tohost;
    logic          mask_ok;
    logic          store_en;

    assign idx       = DataAdr[AW+1:2];
    assign in_range  = (DataAdr < LIMIT);
    assign is_tohost = (DataAdr == TOHOST_ADDR);

    always_comb begin
        case (MemWriteSelect)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: mask_ok = 1'b1;
            default:                   mask_ok = 1'b0;
        endcase
    end

    always_comb begin
        rdata_d  = '0;
        tohost_d = tohost_q;
        done_d   = done_q;
        error_d  = error_q;
        count_d  = count_q;
        store_en = 1'b0;

        if (is_tohost)
            rdata_d = tohost_q;
        else if (in_range)
            rdata_d = mem_q[idx];

        if (MemWrite) begin
            // tohost is decoded ahead of the range check: it lies inside the
            // array window but is never backed by storage.
            if (is_tohost) begin
                if (!done_q) begin
                    if (MemWriteSelect == 4'b1111) begin
                        tohost_d = WriteData;
                        done_d   = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end else if (!mask_ok || !in_range) begin
                error_d = 1'b1;
            end else begin
                store_en = reset;
                if (count_q != 16'hFFFF)
                    count_d = count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q  <= '0;
            tohost_q <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            rdata_q  <= rdata_d;
            tohost_q <= tohost_d;
            done_q   <= done_d;
            error_q  <= error_d;
            count_q  <= count_d;
        end
    end

    // Array is deliberately outside the reset domain; contents survive reset.
    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (MemWriteSelect[b])
                    mem_q[idx][8*b +: 8] <= WriteData[8*b +: 8];
            end
        end
    end

    assign ReadData   = rdata_q;
    assign Done       = done_q;
    assign Pass       = done_q && (tohost_q == PASS_VALUE);
    assign Error      = error_q;
    assign StoreCount = count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: stores, byte lanes, tohost verdict,
// illegal stores, read-first behaviour and asynchronous reset.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [3:0]  MemWriteSelect;
    logic [31:0] ReadData;
    logic        Done;
    logic        Pass;
    logic        Error;
    logic [15:0] StoreCount;

    int tests = 0;
    int fails = 0;

    dmem_responder #(
        .DEPTH       (64),
        .TOHOST_ADDR (32'd100),
        .PASS_VALUE  (32'd25)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .MemWrite       (MemWrite),
        .DataAdr        (DataAdr),
        .WriteData      (WriteData),
        .MemWriteSelect (MemWriteSelect),
        .ReadData       (ReadData),
        .Done           (Done),
        .Pass           (Pass),
        .Error          (Error),
        .StoreCount     (StoreCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] data, input logic [3:0] sel);
        MemWrite       = 1'b1;
        DataAdr        = adr;
        WriteData      = data;
        MemWriteSelect = sel;
        tick();
        MemWrite       = 1'b0;
        MemWriteSelect = 4'b0000;
    endtask

    task automatic load(input logic [31:0] adr);
        MemWrite = 1'b0;
        DataAdr  = adr;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ReadData"},   ReadData, 32'h0);
        check({tag, ".Done"},       {31'h0, Done}, 32'h0);
        check({tag, ".Pass"},       {31'h0, Pass}, 32'h0);
        check({tag, ".Error"},      {31'h0, Error}, 32'h0);
        check({tag, ".StoreCount"}, {16'h0, StoreCount}, 32'h0);
    endtask

    initial begin
        reset          = 1'b0;
        MemWrite       = 1'b0;
        DataAdr        = 32'h0;
        WriteData      = 32'h0;
        MemWriteSelect = 4'b0000;

        // Reset held for 2 cycles
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b1;

        // Basic store and load
        store(32'd96, 32'h0000_0007, 4'b1111);
        load(32'd96);
        check("basic.ReadData", ReadData, 32'h7);
        check("basic.StoreCount", {16'h0, StoreCount}, 32'd1);
        check("basic.Done", {31'h0, Done}, 32'h0);
        check("basic.Error", {31'h0, Error}, 32'h0);

        // Byte lanes on word 8
        store(32'd32, 32'hFFFF_FFFF, 4'b1111);
        store(32'd32, 32'h00AB_0000, 4'b0100);
        load(32'd32);
        check("lane.byte2", ReadData, 32'hFFAB_FFFF);
        store(32'd32, 32'h1234_0000, 4'b1100);
        load(32'd32);
        check("lane.half1", ReadData, 32'h1234_FFFF);
        store(32'd33, 32'h0000_5600, 4'b0010);
        load(32'd32);
        check("lane.byte1", ReadData, 32'h1234_56FF);
        check("lane.StoreCount", {16'h0, StoreCount}, 32'd5);

        // Read-first: word 12 holds 5, then load+store 9 on one edge
        store(32'd12, 32'd5, 4'b1111);
        load(32'd12);
        check("rf.setup", ReadData, 32'd5);
        store(32'd12, 32'd9, 4'b1111);
        check("rf.old", ReadData, 32'd5);
        load(32'd12);
        check("rf.new", ReadData, 32'd9);

        // Back-to-back stores then back-to-back loads, last word in range
        store(32'd248, 32'hCAFE_0001, 4'b1111);
        store(32'd252, 32'hCAFE_0002, 4'b1111);
        load(32'd248);
        check("b2b.first", ReadData, 32'hCAFE_0001);
        load(32'd252);
        check("b2b.second", ReadData, 32'hCAFE_0002);
        check("b2b.StoreCount", {16'h0, StoreCount}, 32'd9);

        // Completion with PASS_VALUE
        check("tohost.preDone", {31'h0, Done}, 32'h0);
        store(32'd100, 32'd25, 4'b1111);
        check("tohost.Done", {31'h0, Done}, 32'h1);
        check("tohost.Pass", {31'h0, Pass}, 32'h1);
        check("tohost.Count", {16'h0, StoreCount}, 32'd9);
        store(32'd100, 32'd3, 4'b1111);
        check("tohost.frozenPass", {31'h0, Pass}, 32'h1);
        store(32'd100, 32'd3, 4'b0011);
        check("tohost.ignoredErr", {31'h0, Error}, 32'h0);
        load(32'd100);
        check("tohost.load", ReadData, 32'd25);
        check("tohost.Count2", {16'h0, StoreCount}, 32'd9);

        // Illegal stores; word 0 set up first
        store(32'd0, 32'hA5A5_0001, 4'b1111);
        check("ill.preErr", {31'h0, Error}, 32'h0);
        store(32'd0, 32'h0000_0000, 4'b0101);
        check("ill.maskErr", {31'h0, Error}, 32'h1);
        check("ill.maskCount", {16'h0, StoreCount}, 32'd10);
        store(32'd256, 32'h1111_1111, 4'b1111);
        check("ill.rangeCount", {16'h0, StoreCount}, 32'd10);
        store(32'd4, 32'h2222_2222, 4'b0000);
        check("ill.zeroMaskCount", {16'h0, StoreCount}, 32'd10);
        load(32'd0);
        check("ill.word0", ReadData, 32'hA5A5_0001);
        load(32'd256);
        check("ill.oorLoad", ReadData, 32'h0);

        // Async reset mid-cycle; store during reset is lost
        load(32'd0);
        #3;
        reset = 1'b0;
        #1;
        check_all_zero("areset");
        MemWrite       = 1'b1;
        DataAdr        = 32'd0;
        WriteData      = 32'd77;
        MemWriteSelect = 4'b1111;
        tick();
        MemWrite       = 1'b0;
        MemWriteSelect = 4'b0000;
        reset          = 1'b1;
        load(32'd0);
        check("areset.word0Kept", ReadData, 32'hA5A5_0001);
        check("areset.Count", {16'h0, StoreCount}, 32'd0);

        // Fail path
        store(32'd100, 32'd26, 4'b1111);
        check("fail.Done", {31'h0, Done}, 32'h1);
        check("fail.Pass", {31'h0, Pass}, 32'h0);
        check("fail.Error", {31'h0, Error}, 32'h0);
        load(32'd100);
        check("fail.load", ReadData, 32'd26);

        // Partial-mask tohost store before Done is illegal
        reset = 1'b0;
        #2;
        reset = 1'b1;
        store(32'd100, 32'd25, 4'b0011);
        check("thbad.Error", {31'h0, Error}, 32'h1);
        check("thbad.Done", {31'h0, Done}, 32'h0);
        load(32'd100);
        check("thbad.load", ReadData, 32'h0);
        check("thbad.Count", {16'h0, StoreCount}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
